// File: rtl/axi_burst_ram.sv
// AXI4 burst-capable slave RAM with independent read and write channels.
// Each channel holds at most one outstanding transaction. Addresses alias
// modulo the RAM depth. Narrow sizes, WRAP and reserved bursts get SLVERR.
//
// state   | meaning
// W_IDLE  | waiting for a write address, awready high
// W_DATA  | accepting write beats, wready high
// W_RESP  | holding the write response until bready
// R_IDLE  | waiting for a read address, arready high
// R_DATA  | presenting read beats, rvalid high
module axi_burst_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(STRB_WIDTH);
    localparam int IDX_BITS   = $clog2(DEPTH_WORDS);
    localparam logic [2:0] FULL_SIZE = 3'(OFF_BITS);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    w_state_t w_state, w_state_next;
    r_state_t r_state, r_state_next;

    logic [ID_WIDTH-1:0] w_id, r_id;
    logic [IDX_BITS-1:0] w_idx, r_idx, aw_idx, ar_idx, r_idx_next;
    logic [7:0]          w_cnt, r_cnt;
    logic                w_fixed, w_cfg_err, w_last_err;
    logic                r_fixed, r_err;
    logic                aw_err, ar_err;
    logic                aw_hs, w_hs, ar_hs, r_hs;
    logic                unused_addr;

    // Upper address bits only alias, so they are deliberately dropped.
    assign unused_addr = ^{s_awaddr, s_araddr};

    assign aw_idx = s_awaddr[OFF_BITS +: IDX_BITS];
    assign ar_idx = s_araddr[OFF_BITS +: IDX_BITS];
    assign aw_err = (s_awsize != FULL_SIZE) || s_awburst[1];
    assign ar_err = (s_arsize != FULL_SIZE) || s_arburst[1];

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    assign s_bid   = w_id;
    assign s_bresp = (s_bvalid && (w_cfg_err || w_last_err)) ? RESP_SLVERR : 2'b00;
    assign s_rid   = r_id;
    assign s_rresp = (s_rvalid && r_err) ? RESP_SLVERR : 2'b00;

    assign r_idx_next = r_fixed ? r_idx : r_idx + IDX_BITS'(1);

    // State registers for both channel FSMs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_state_next;
            r_state <= r_state_next;
        end
    end

    // Write FSM next state and handshake outputs.
    always_comb begin
        w_state_next = w_state;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_awready = 1'b1;
                if (s_awvalid) w_state_next = W_DATA;
            end
            W_DATA: begin
                s_wready = 1'b1;
                if (s_wvalid && (w_cnt == 8'd0)) w_state_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write burst context; the beat count, not wlast, ends the burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_id       <= '0;
            w_idx      <= '0;
            w_cnt      <= '0;
            w_fixed    <= 1'b0;
            w_cfg_err  <= 1'b0;
            w_last_err <= 1'b0;
        end else if (aw_hs) begin
            w_id       <= s_awid;
            w_idx      <= aw_idx;
            w_cnt      <= s_awlen;
            w_fixed    <= (s_awburst == 2'b00);
            w_cfg_err  <= aw_err;
            w_last_err <= 1'b0;
        end else if (w_hs) begin
            w_cnt <= w_cnt - 8'd1;
            if (!w_fixed) w_idx <= w_idx + IDX_BITS'(1);
            if (s_wlast != (w_cnt == 8'd0)) w_last_err <= 1'b1;
        end
    end

    // RAM byte writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_hs && !w_cfg_err) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (s_wstrb[i]) mem[w_idx][i*8 +: 8] <= s_wdata[i*8 +: 8];
            end
        end
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        r_state_next = r_state;
        s_arready    = 1'b0;
        s_rvalid     = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_arready = 1'b1;
                if (s_arvalid) r_state_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid = 1'b1;
                if (s_rready && s_rlast) r_state_next = R_IDLE;
            end
        endcase
    end

    // Read burst context and registered read data; a same-cycle write is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id    <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_fixed <= 1'b0;
            r_err   <= 1'b0;
            s_rdata <= '0;
            s_rlast <= 1'b0;
        end else if (ar_hs) begin
            r_id    <= s_arid;
            r_idx   <= ar_idx;
            r_cnt   <= s_arlen;
            r_fixed <= (s_arburst == 2'b00);
            r_err   <= ar_err;
            s_rdata <= ar_err ? '0 : mem[ar_idx];
            s_rlast <= (s_arlen == 8'd0);
        end else if (r_hs) begin
            if (s_rlast) begin
                s_rlast <= 1'b0;
            end else begin
                r_idx   <= r_idx_next;
                r_cnt   <= r_cnt - 8'd1;
                s_rdata <= r_err ? '0 : mem[r_idx_next];
                s_rlast <= (r_cnt == 8'd1);
            end
        end
    end
endmodule
